// File: rtl/regfile_pkg.sv
// Shared register-bank constants and address qualification.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Purpose: default bank geometry, reset word and the address-validity
// helper shared by the write gate and the read masking.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;

  // Reset contents of every register and output; sliced to WIDTH at use.
  localparam int            MAX_WIDTH  = 256;
  localparam logic [MAX_WIDTH-1:0] RESET_WORD = '0;

  // An address is usable when it is inside the bank and is not the
  // hard-wired zero register.
  function automatic logic addr_valid(input int addr, input int depth, input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/register_bank_rdport.sv
// One registered read port: enable/zero masking, optional write bypass.
// Latency: 1 cycle from rd_addr/rd_en to rd_data.
// Backpressure: none; the output reloads on every edge.
//
// Ports: clk/clr (async active-low), rd_en/rd_addr select, mem_word is the
// raw storage word at rd_addr, wr_en/wr_addr/wr_data observe the write port
// for collision forwarding, rd_data is the registered result.
// Build option: REGISTER_BANK_BYPASS_EN selects write-first on collisions;
// otherwise the old contents are returned (read-first).
module register_bank_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic             rd_ok;
  logic [WIDTH-1:0] word;

  assign rd_ok = addr_valid(int'(rd_addr), DEPTH, ZERO_REG != 0);

`ifdef REGISTER_BANK_BYPASS_EN
  // rd_ok already excludes r0/out-of-range, so those never forward.
  assign word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_word;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign word      = mem_word;
`endif

  always_comb begin
    rd_data_d = RESET_WORD[WIDTH-1:0];
    if (rd_en && rd_ok) rd_data_d = word;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rd_data_q <= RESET_WORD[WIDTH-1:0];
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register file, one write port, two registered read ports.
// Latency: write visible to reads one edge later (same edge if bypassed).
// Backpressure: none; all ports accept every cycle.
//
// Ports: clk, clr (async active-low); input_enable/wr_addr/wr_data write;
// output_enable_a/rd_addr_a -> rd_data_a and output_enable_b/rd_addr_b ->
// rd_data_b, each registered with a disabled port reading zero.
// Build option: REGISTER_BANK_BYPASS_EN (write-first collision forwarding).
module register_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             input_enable,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             output_enable_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic             output_enable_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] word_a, word_b;

  assign wr_ok = input_enable && addr_valid(int'(wr_addr), DEPTH, ZERO_REG != 0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) mem_q <= '{default: RESET_WORD[WIDTH-1:0]};
    else      mem_q <= mem_d;
  end

  // Guard the array select: with a non-power-of-two DEPTH the address
  // field can name entries that do not exist.
  assign word_a = (int'(rd_addr_a) < DEPTH) ? mem_q[rd_addr_a] : RESET_WORD[WIDTH-1:0];
  assign word_b = (int'(rd_addr_b) < DEPTH) ? mem_q[rd_addr_b] : RESET_WORD[WIDTH-1:0];

  register_bank_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_rd_a (
    .clk      (clk),
    .clr      (clr),
    .rd_en    (output_enable_a),
    .rd_addr  (rd_addr_a),
    .mem_word (word_a),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_a)
  );

  register_bank_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_rd_b (
    .clk      (clk),
    .clr      (clr),
    .rd_en    (output_enable_b),
    .rd_addr  (rd_addr_b),
    .mem_word (word_b),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_b)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank (WIDTH=32, DEPTH=12, ZERO_REG=1).
module tb_register_bank;

  localparam int W  = 32;
  localparam int D  = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          input_enable;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          output_enable_a, output_enable_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [W-1:0]  rd_data_a, rd_data_b;

  int n_checks = 0;
  int n_errors = 0;

  register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk             (clk),
    .clr             (clr),
    .input_enable    (input_enable),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .output_enable_a (output_enable_a),
    .rd_addr_a       (rd_addr_a),
    .rd_data_a       (rd_data_a),
    .output_enable_b (output_enable_b),
    .rd_addr_b       (rd_addr_b),
    .rd_data_b       (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    input_enable = 1'b1; wr_addr = a; wr_data = d;
    tick();
    input_enable = 1'b0;
  endtask

  task automatic rd(input logic ea, input logic [AW-1:0] aa, input logic eb, input logic [AW-1:0] ab);
    output_enable_a = ea; rd_addr_a = aa;
    output_enable_b = eb; rd_addr_b = ab;
    tick();
  endtask

  // Hand-computed expected register contents after the directed writes.
  logic [W-1:0] exp_mem [16];
  logic [W-1:0] ea, eb;
  logic [AW-1:0] ra, rb, wa;
  logic          we, oa, ob;
  logic [W-1:0]  wd;

  initial begin
    clr = 1'b0; input_enable = 1'b0; wr_addr = '0; wr_data = '0;
    output_enable_a = 1'b0; output_enable_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    #3;
    check("reset_a", rd_data_a, 32'h0);
    check("reset_b", rd_data_b, 32'h0);
    // Edges while clr is low are ignored.
    input_enable = 1'b1; wr_addr = 4'd2; wr_data = 32'h99;
    tick();
    input_enable = 1'b0;
    #3 clr = 1'b1;
    rd(1'b1, 4'd2, 1'b0, 4'd0);
    check("write_during_reset", rd_data_a, 32'h0);

    // Reset discards stored data and clears outputs asynchronously.
    wr(4'd3, 32'd24);
    rd(1'b1, 4'd3, 1'b1, 4'd3);
    check("r3_before_clr", rd_data_a, 32'd24);
    #2 clr = 1'b0;
    #1;
    check("clr_async_a", rd_data_a, 32'h0);
    check("clr_async_b", rd_data_b, 32'h0);
    #1 clr = 1'b1;
    rd(1'b1, 4'd3, 1'b0, 4'd0);
    check("r3_after_clr", rd_data_a, 32'h0);

    // Basic write / dual read.
    wr(4'd5, 32'd24);
    wr(4'd7, 32'hDEADBEEF);
    rd(1'b1, 4'd5, 1'b1, 4'd7);
    check("read_a_r5", rd_data_a, 32'd24);
    check("read_b_r7", rd_data_b, 32'hDEADBEEF);

    // Output enable drop.
    rd(1'b0, 4'd5, 1'b1, 4'd7);
    check("oe_a_off", rd_data_a, 32'h0);
    check("oe_b_kept", rd_data_b, 32'hDEADBEEF);

    // Same address on both ports.
    rd(1'b1, 4'd7, 1'b1, 4'd7);
    check("same_addr_a", rd_data_a, 32'hDEADBEEF);
    check("same_addr_b", rd_data_b, 32'hDEADBEEF);

    // Zero register.
    wr(4'd0, 32'd55);
    rd(1'b1, 4'd0, 1'b1, 4'd0);
    check("r0_a", rd_data_a, 32'h0);
    check("r0_b", rd_data_b, 32'h0);

    // Last valid entry and out-of-range addresses.
    wr(4'd11, 32'hA5A5_0011);
    wr(4'd13, 32'h77);
    wr(4'd12, 32'h66);
    rd(1'b1, 4'd11, 1'b1, 4'd13);
    check("r11_last", rd_data_a, 32'hA5A5_0011);
    check("oob_13", rd_data_b, 32'h0);
    rd(1'b1, 4'd12, 1'b1, 4'd15);
    check("oob_12", rd_data_a, 32'h0);
    check("oob_15", rd_data_b, 32'h0);

    // Sweep all entries: out-of-range writes must not alias anywhere.
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    exp_mem[5]  = 32'd24;
    exp_mem[7]  = 32'hDEADBEEF;
    exp_mem[11] = 32'hA5A5_0011;
    for (int i = 0; i < D; i++) begin
      rd(1'b1, AW'(i), 1'b0, 4'd0);
      check($sformatf("sweep_r%0d", i), rd_data_a, exp_mem[i]);
    end

    // Read/write collision.
    wr(4'd9, 32'd1);
    input_enable = 1'b1; wr_addr = 4'd9; wr_data = 32'd2;
    rd(1'b1, 4'd9, 1'b1, 4'd0);
    input_enable = 1'b0;
`ifdef REGISTER_BANK_BYPASS_EN
    check("collide_same_edge", rd_data_a, 32'd2);
`else
    check("collide_same_edge", rd_data_a, 32'd1);
`endif
    rd(1'b1, 4'd9, 1'b0, 4'd0);
    check("collide_next_edge", rd_data_a, 32'd2);
    exp_mem[9] = 32'd2;

    // Collision on r0 never forwards.
    input_enable = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234;
    rd(1'b1, 4'd0, 1'b0, 4'd0);
    input_enable = 1'b0;
    check("collide_r0", rd_data_a, 32'h0);

    // Pseudo-random traffic against the reference array.
    for (int c = 0; c < 200; c++) begin
      we = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(0, 15)); wd = $urandom;
      oa = 1'($urandom_range(0, 3) != 0); ra = AW'($urandom_range(0, 15));
      ob = 1'($urandom_range(0, 3) != 0); rb = AW'($urandom_range(0, 15));
      ea = (oa && ra != 0 && ra < D) ? exp_mem[ra] : 32'h0;
      eb = (ob && rb != 0 && rb < D) ? exp_mem[rb] : 32'h0;
`ifdef REGISTER_BANK_BYPASS_EN
      if (we && oa && ra == wa && ra != 0 && ra < D) ea = wd;
      if (we && ob && rb == wa && rb != 0 && rb < D) eb = wd;
`endif
      if (we && wa != 0 && wa < D) exp_mem[wa] = wd;
      input_enable = we; wr_addr = wa; wr_data = wd;
      rd(oa, ra, ob, rb);
      input_enable = 1'b0;
      check("rand_a", rd_data_a, ea);
      check("rand_b", rd_data_b, eb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
